// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks.
package async_fifo_pkg;

  localparam int unsigned DsizeDefault = 8;

  // StIdle: no pending word, StHold: one popped word waiting in the pending register.
  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_framer_if.sv
// FIFO read port plus framed output stream; master is the framer side.
interface fifo_rd_framer_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DsizeDefault
) ();

  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data, m_last
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_rd_outreg.sv
// Single-entry output register: loads a word when asked, drops valid once it is accepted.
module fifo_rd_outreg
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DsizeDefault
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             load,
  input  logic [DSIZE-1:0] ld_data,
  input  logic             ld_last,
  input  logic             ready,
  output logic             valid,
  output logic [DSIZE-1:0] data,
  output logic             last
);

  logic             valid_q;
  logic [DSIZE-1:0] data_q;
  logic             last_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= ld_data;
      last_q  <= ld_last;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: rtl/fifo_rd_framer.sv
// Pops a first-word-fall-through FIFO and emits framed words, closing partial frames on idle.
// Optional FIFO_RD_FRAMER_STATS_EN adds 16-bit frame_cnt and tmo_cnt outputs.
module fifo_rd_framer
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = DsizeDefault,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  fifo_rd_framer_if.master       bus
`ifdef FIFO_RD_FRAMER_STATS_EN
  ,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            tmo_cnt
`endif
);

  localparam int unsigned     BeatW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(FRAME_LEN - 1);
  localparam logic [15:0]      IdleLast = 16'(TIMEOUT - 1);

  rd_state_e        state_q, state_d;
  logic [DSIZE-1:0] pend_data_q;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [15:0]      idle_q, idle_d;

  logic pend_v, out_ld, rinc, pend_last, timeout, emit, emit_last;

  assign pend_v    = (state_q == StHold);
  assign out_ld    = !bus.m_valid || bus.m_ready;
  // Reset gating keeps the FIFO untouched while the block is held in reset.
  assign rinc      = rrst_n && !bus.rempty && (!pend_v || out_ld);
  assign bus.rinc  = rinc;
  assign pend_last = pend_v && (beat_q == BeatLast);
  assign timeout   = pend_v && bus.rempty && (idle_q == IdleLast);
  assign emit      = pend_v && out_ld && (rinc || pend_last || timeout);
  assign emit_last = (beat_q == BeatLast) || timeout;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idle_d  = '0;
    case (state_q)
      StIdle:  if (rinc) state_d = StHold;
      StHold:  if (emit && !rinc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (emit) beat_d = emit_last ? '0 : beat_q + BeatW'(1);
    // Saturate so a timeout blocked by a stalled output stays asserted.
    if (pend_v && bus.rempty && !emit) begin
      idle_d = (idle_q == IdleLast) ? idle_q : idle_q + 16'd1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= StIdle;
      pend_data_q <= '0;
      beat_q      <= '0;
      idle_q      <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      if (rinc) pend_data_q <= bus.rdata;
    end
  end

  fifo_rd_outreg #(
    .DSIZE (DSIZE)
  ) u_outreg (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .load    (emit),
    .ld_data (pend_data_q),
    .ld_last (emit_last),
    .ready   (bus.m_ready),
    .valid   (bus.m_valid),
    .data    (bus.m_data),
    .last    (bus.m_last)
  );

`ifdef FIFO_RD_FRAMER_STATS_EN
  logic        tmo_emit;
  logic [15:0] frame_cnt_q, tmo_cnt_q;

  assign tmo_emit = emit && timeout && !pend_last;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      frame_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      if (bus.m_valid && bus.m_ready && bus.m_last) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (tmo_emit) tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign tmo_cnt   = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Scoreboard bench for fifo_rd_framer driven from a behavioural FWFT FIFO model.
// Stats outputs are checked when FIFO_RD_FRAMER_STATS_EN is defined.
module tb_fifo_rd_framer;

  localparam int unsigned DSIZE     = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned TIMEOUT   = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       lst;
  } exp_t;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b1;

  fifo_rd_framer_if #(.DSIZE(DSIZE)) bus ();

`ifdef FIFO_RD_FRAMER_STATS_EN
  logic [15:0] frame_cnt, tmo_cnt;
`endif

  fifo_rd_framer #(
    .DSIZE     (DSIZE),
    .FRAME_LEN (FRAME_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .bus       (bus)
`ifdef FIFO_RD_FRAMER_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .tmo_cnt   (tmo_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  // FWFT FIFO model: head word visible whenever non-empty.
  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.rempty = (wr_ptr == rd_ptr);
  assign bus.rdata  = mem[rd_ptr[5:0]];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0, pops = 0, last_pop_edge = 0;
  int   xfers = 0, dropped = 0;
  int   exp_frames = 0, exp_tmo = 0;
  exp_t sb_q[$];
  logic [3:0] rdy_pat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge rclk) begin
    cyc = cyc + 1;
    if (bus.rinc && !bus.rempty) begin
      pops          = pops + 1;
      last_pop_edge = cyc;
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Output monitor: scoreboard compare, stall stability and pop-while-held checks.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;
  always @(negedge rclk) begin
    exp_t e;
    if (!rrst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.rempty) check("rinc_when_empty", 32'(bus.rinc), 0);
      if (prev_stall)
        check("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, prev_last, prev_data});
      if (bus.m_valid && !bus.m_ready)
        check("pop_while_held", 32'(bus.rinc && ((pops - xfers - dropped - 1) != 0)), 0);
      if (bus.m_valid && bus.m_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("data", 32'(bus.m_data), 32'(e.data));
          check("last", 32'(bus.m_last), 32'(e.lst));
        end
        xfers = xfers + 1;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  task automatic push_word(input logic [7:0] d, input logic lst, input logic tmo);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
    sb_q.push_back('{data: d, lst: lst});
    if (lst) exp_frames++;
    if (tmo) exp_tmo++;
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge rclk);
      #1;
      if (bus.m_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input int limit, input bit toggle);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(posedge rclk);
      #1;
      if (toggle) bus.m_ready = rdy_pat[i % 4];
      @(negedge rclk);
      #1;
      if (sb_q.size() == 0 && bus.rempty) done = 1'b1;
    end
    check("drain_done", 32'(done), 1);
    bus.m_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic check_stats();
`ifdef FIFO_RD_FRAMER_STATS_EN
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("tmo_cnt", 32'(tmo_cnt), 32'(exp_tmo));
`endif
  endtask

  initial begin
    bit seen;
    bus.m_ready = 1'b1;

    // Reset state
    #2 rrst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.m_valid), 0);
    check("rst_last", 32'(bus.m_last), 0);
    check("rst_data", 32'(bus.m_data), 0);
    check("rst_rinc", 32'(bus.rinc), 0);
    check_stats();
    #19 rrst_n = 1'b1;

    // Empty FIFO: nothing happens
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      #1;
      check("empty_no_valid", 32'(bus.m_valid), 0);
    end

    // Eight preloaded words stream back to back, two frames
    tick();
    for (int k = 1; k <= 8; k++) push_word(8'(k), (k == 4) || (k == 8), 1'b0);
    wait_valid(10, seen);
    check("thru_start", 32'(seen), 1);
    for (int j = 0; j < 8; j++) begin
      check("thru_valid", 32'(bus.m_valid), 1);
      if (j < 7) begin
        @(negedge rclk);
        #1;
      end
    end
    drain(20, 1'b0);
    check_stats();

    // Lone word closes its frame after TIMEOUT cycles
    push_word(8'hA5, 1'b1, 1'b1);
    wait_valid(40, seen);
    check("tmo_seen", 32'(seen), 1);
    check("tmo_latency", 32'(cyc - last_pop_edge), TIMEOUT);
    drain(20, 1'b0);
    check_stats();

    // Full frame, short gap, then a frame with a pending word across a gap
    for (int k = 0; k < 4; k++) push_word(8'(8'h10 + k), k == 3, 1'b0);
    drain(20, 1'b0);
    repeat (5) tick();
    push_word(8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      #1;
      check("gap_hold", 32'(bus.m_valid), 0);
    end
    tick();
    for (int k = 5; k < 8; k++) push_word(8'(8'h10 + k), k == 7, 1'b0);
    drain(30, 1'b0);
    check_stats();

    // Backpressure pattern 1,0,0,1
    for (int k = 0; k < 6; k++) push_word(8'(8'h30 + k), (k == 3) || (k == 5), k == 5);
    drain(200, 1'b1);
    check_stats();

    // Reset mid-frame: 0x40 accepted, 0x41 held at output, 0x42 pending
    bus.m_ready = 1'b0;
    tick();
    push_word(8'h40, 1'b0, 1'b0);
    push_word(8'h41, 1'b0, 1'b0);
    push_word(8'h42, 1'b0, 1'b0);
    wait_valid(10, seen);
    check("pre_rst_seen", 32'(seen), 1);
    tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    @(negedge rclk);
    #1;
    check("pre_rst_valid", 32'(bus.m_valid), 1);
    check("pre_rst_data", 32'(bus.m_data), 32'h41);
    @(posedge rclk);
    #3;
    rrst_n     = 1'b0;
    dropped    = pops - xfers;
    sb_q.delete();
    exp_frames = 0;
    exp_tmo    = 0;
    #1;
    check("midrst_valid", 32'(bus.m_valid), 0);
    check("midrst_last", 32'(bus.m_last), 0);
    check("midrst_data", 32'(bus.m_data), 0);
    check_stats();
    push_word(8'h43, 1'b0, 1'b0);
    @(negedge rclk);
    #1;
    check("midrst_rinc", 32'(bus.rinc), 0);
    rrst_n      = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    for (int k = 4; k < 7; k++) push_word(8'(8'h40 + k), k == 6, 1'b0);
    drain(30, 1'b0);
    check_stats();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_framer.md
FIFO_RD_FRAMER -- requirements
Module: fifo_rd_framer

Interface
REQ-001 SHALL have parameter DSIZE, default 8, meaning word width; it matches the async FIFO DSIZE.
REQ-002 SHALL have parameter FRAME_LEN, default 4, meaning words per full frame; legal range 2..256.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning idle cycles before a partial frame closes; legal range 1..65535.
REQ-004 SHALL have one clock and an asynchronous active-low reset; this is fixed.
REQ-005 rclk  in  1  read-domain clock; all logic on its rising edge.
REQ-006 rrst_n  in  1  asynchronous active-low reset.
REQ-007 rempty  in  1  FIFO empty flag; rdata is valid whenever rempty=0 (first-word fall-through).
REQ-008 rdata  in  DSIZE  FIFO head word.
REQ-009 rinc  out  1  FIFO pop, combinational, and SHALL never be 1 while rempty=1.
REQ-010 m_valid  out  1  output word valid.
REQ-011 m_ready  in  1  downstream accept; a transfer is m_valid & m_ready.
REQ-012 m_data  out  DSIZE  output word.
REQ-013 m_last  out  1  marks the final word of a frame.

Function
REQ-014 SHALL hold at most one popped word in a pending register (pend_v, pend_data) and one word in the output register (m_valid, m_data, m_last).
REQ-015 State machine SHALL have two states, IDLE (pend_v=0) and HOLD (pend_v=1).
REQ-016 SHALL define out_ld = !m_valid | m_ready.
REQ-017 SHALL drive rinc = !rempty & (!pend_v | out_ld).
REQ-018 The pending word SHALL move to the output register when out_ld and any of the following holds: rinc, pend_last, or timeout.
REQ-019 Emitted m_last SHALL be 1 when the beat counter = FRAME_LEN-1 or on a timeout emission, else 0.
REQ-020 The beat counter SHALL increment on each emission, and clear to 0 after an emission with m_last=1.
REQ-021 pend_last SHALL be 1 when the pending word is beat FRAME_LEN-1; it is then emitted without waiting for the next FIFO word.
REQ-022 The idle counter SHALL count cycles with pend_v & rempty, clear otherwise, and raise timeout at TIMEOUT-1.
REQ-023 Emission and a pop in the same cycle SHALL load pending with rdata, so the state remains HOLD.
REQ-024 Emission without a pop SHALL transition to IDLE.
REQ-025 With m_ready=0 and m_valid=1, SHALL hold m_data/m_last stable; a pop is allowed only when pend_v=0.
REQ-026 Word order SHALL be preserved; no word is dropped or duplicated.
REQ-027 Throughput SHALL be 1 word/cycle sustained with m_ready=1 and a non-empty FIFO.
REQ-028 Latency from the first pop to m_valid SHALL be 1 cycle when the next word is present, or TIMEOUT cycles for a lone word.

Reset
REQ-029 Assertion of rrst_n=0 SHALL immediately force m_valid=0, m_last=0, m_data=0, pend_v=0, beat=0, idle=0, and state IDLE.
REQ-030 rinc SHALL be 0 during reset; a reset mid-frame discards pending and output words, and the next frame restarts at beat 0.
REQ-031 Deassertion of reset SHALL be synchronised by the instantiating level; the block takes no deassertion action.

Configuration
REQ-032 With macro FIFO_RD_FRAMER_STATS_EN defined, SHALL add outputs frame_cnt (16 bit, +1 per m_last transfer) and tmo_cnt (16 bit, +1 per timeout emission); both wrap, and both reset to 0.
REQ-033 Without FIFO_RD_FRAMER_STATS_EN, those ports and counters SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-034 The state enum (IDLE, HOLD) and the default DSIZE constant SHALL live in the shared package async_fifo_pkg.
REQ-035 The output register SHALL be a sub-module fifo_rd_outreg (valid/data/last with load/ready); the framing logic stays in the top.

Verification
REQ-036 8 words 0x01..0x08 are preloaded, m_ready=1 -> output 0x01..0x08 on consecutive cycles, with m_last on 0x04 and 0x08.
REQ-037 A single word 0xA5 is followed by an empty FIFO -> 0xA5 appears with m_last=1 exactly TIMEOUT=16 cycles after the pop, and tmo_cnt=1 when the macro is defined.
REQ-038 6 words are queued while m_ready is toggled 1,0,0,1 repeating -> the sequence is intact, m_data is stable while stalled, rinc is never 1 with pend_v=1 and out_ld=0.
REQ-039 rempty=1 throughout -> rinc=0 and m_valid=0 forever.
REQ-040 rrst_n is pulsed low after word 2 of a frame -> outputs clear immediately, and the next words restart at beat 0 with m_last on the 4th word.
REQ-041 Written 0x10..0x13 are read and a gap of 5 cycles (<TIMEOUT) is followed by 0x14 -> m_last on 0x13 only, with no timeout emission.
